// File: rtl/axis_to_axi_read_burst_fifo_pkg.sv
// Shared AXI read-burst constants and the responder FSM state type.
package axi_burst_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, ERR} state_e;

  // Only full-width FIXED/INCR bursts are served from the FIFO; anything else errors.
  function automatic logic burst_ok(input logic [1:0] burst, input logic [2:0] size,
                                    input logic [2:0] size_native);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == size_native);
  endfunction

endpackage

// File: rtl/axis_to_axi_read_burst_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry an extra wrap bit.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_WIDTH = 16,
  localparam int AW = $clog2(FIFO_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [AW:0]           count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_WIDTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/axis_to_axi_read_burst_fifo.sv
// AXI4 read-burst responder draining an AXI-Stream-fed FIFO; one burst in flight.
module axis_to_axi_read_burst_fifo
  import axi_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [ADDR_WIDTH-1:0]       araddr,
  input  logic [ADDR_WIDTH/4-1:0]     arlen,
  input  logic [2:0]                  arsize,
  input  logic [1:0]                  arburst,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic                        rvalid,
  input  logic                        rready,
  output logic [$clog2(FIFO_WIDTH):0] fifo_count
);

  localparam int LEN_W = ADDR_WIDTH/4;
  localparam logic [2:0] SIZE_NATIVE = 3'($clog2(DATA_WIDTH/8));

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic                    fifo_full, fifo_empty, pop, ar_hs, r_hs;
  logic [DATA_WIDTH-1:0]   fifo_head;
  logic                    unused_araddr;

  // Address is captured for observability only; the FIFO has no address space.
  assign unused_araddr = ^araddr_q;

  assign s_axis_tready = ~areset & ~fifo_full;
  assign ar_hs         = arvalid & arready;
  assign r_hs          = rvalid & rready;
  assign pop           = (state_q == READ) & r_hs;

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_WIDTH(FIFO_WIDTH)) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (s_axis_tvalid & s_axis_tready),
    .wdata_i (s_axis_tdata),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      araddr_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      if (ar_hs) araddr_q <= araddr;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          remaining_d = arlen;
          state_d     = burst_ok(arburst, arsize, SIZE_NATIVE) ? READ : ERR;
        end
      end
      READ, ERR: begin
        if (r_hs) begin
          if (remaining_q == '0) state_d = IDLE;
          else                   remaining_d = remaining_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are held at reset values while areset is high, whatever the state.
  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = RESP_OKAY;
    rlast   = 1'b0;
    if (!areset) begin
      unique case (state_q)
        IDLE: arready = 1'b1;
        READ: begin
          rvalid = ~fifo_empty;
          rdata  = fifo_head;
          rlast  = (remaining_q == '0);
        end
        ERR: begin
          rvalid = 1'b1;
          rresp  = RESP_SLVERR;
          rlast  = (remaining_q == '0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_to_axi_read_burst_fifo.sv
// Self-checking bench: R-beat scoreboard plus a table of AR bursts and hand sequences.
module tb_axis_to_axi_read_burst_fifo;
  import axi_burst_pkg::*;

  localparam int DW = 32;
  localparam int AWD = 32;
  localparam int FW = 16;
  localparam int LW = AWD/4;
  localparam int CW = $clog2(FW)+1;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic [AWD-1:0] araddr;
  logic [LW-1:0] arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [CW-1:0] fifo_count;

  axis_to_axi_read_burst_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .FIFO_WIDTH(FW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .fifo_count(fifo_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  typedef struct {
    logic [LW-1:0] len;
    logic [2:0]    size;
    logic [1:0]    burst;
    int            pre;
    bit            err;
    int            exp_cnt;
  } vec_t;

  beat_t         exp_q[$];
  logic [DW-1:0] mq[$];
  int            checks = 0;
  int            errors = 0;
  bit            done;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  beat_t         mon_e;
  logic          p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0;
  logic [1:0]    p_resp = '0;
  logic [DW-1:0] p_data = '0;
  always @(negedge aclk) begin
    if (areset) begin
      p_vld <= 1'b0;
    end else begin
      if (p_vld && !p_rdy) begin
        check("stall_rvalid", 64'(rvalid), 64'(1));
        check("stall_rdata", 64'(rdata), 64'(p_data));
        check("stall_rlast", 64'(rlast), 64'(p_last));
        check("stall_rresp", 64'(rresp), 64'(p_resp));
      end
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got rdata 0x%0h rlast %0d, expected no beat", rdata, rlast);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_rdata", 64'(rdata), 64'(mon_e.data));
          check("beat_rresp", 64'(rresp), 64'(mon_e.resp));
          check("beat_rlast", 64'(rlast), 64'(mon_e.last));
        end
      end
      p_vld  <= rvalid;
      p_rdy  <= rready;
      p_data <= rdata;
      p_last <= rlast;
      p_resp <= rresp;
    end
  end

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  // All driving tasks start and end 1 time unit after a rising edge.
  task automatic push(input logic [DW-1:0] d);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && n < 200) begin @(negedge aclk); n++; end
    if (!s_axis_tready) fail("push_wait");
    else mq.push_back(d);
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic ar(input logic [LW-1:0] len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    araddr  = 32'h1000_0000;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (!arready) fail("ar_wait");
    tick();
    arvalid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
    if (exp_q.size() != 0) begin
      fail("burst_wait");
      exp_q.delete();
    end
  endtask

  task automatic exp_ok(input int n, input bit last_end);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = mq.pop_front();
      b.resp = RESP_OKAY;
      b.last = last_end && (i == n-1);
      exp_q.push_back(b);
    end
  endtask

  task automatic exp_err(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = '0;
      b.resp = RESP_SLVERR;
      b.last = (i == n-1);
      exp_q.push_back(b);
    end
  endtask

  task automatic check_rst_vals(input string tag);
    check({tag, "_arready"}, 64'(arready), 64'(0));
    check({tag, "_tready"}, 64'(s_axis_tready), 64'(0));
    check({tag, "_rvalid"}, 64'(rvalid), 64'(0));
    check({tag, "_rlast"}, 64'(rlast), 64'(0));
    check({tag, "_rresp"}, 64'(rresp), 64'(0));
    check({tag, "_rdata"}, 64'(rdata), 64'(0));
    check({tag, "_count"}, 64'(fifo_count), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vec[7];
    beat_t b;
    vec[0] = '{8'd3, 3'd2, BURST_INCR,  0, 1'b0, 1};
    vec[1] = '{8'd0, 3'd2, BURST_FIXED, 0, 1'b0, 1};
    vec[2] = '{8'd1, 3'd2, 2'b11,       2, 1'b1, 3};
    vec[3] = '{8'd2, 3'd2, BURST_WRAP,  0, 1'b1, 3};
    vec[4] = '{8'd1, 3'd1, BURST_INCR,  0, 1'b1, 3};
    vec[5] = '{8'd0, 3'd3, BURST_FIXED, 0, 1'b1, 3};
    vec[6] = '{8'd7, 3'd2, BURST_INCR,  0, 1'b0, 3};

    areset = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) tick();
    @(negedge aclk);
    check_rst_vals("reset");
    tick();
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_arready", 64'(arready), 64'(1));
    check("post_rst_tready", 64'(s_axis_tready), 64'(1));
    tick();

    // Basic INCR burst of four pre-buffered words.
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
    @(negedge aclk);
    check("t1_count", 64'(fifo_count), 64'(4));
    tick();
    for (int i = 0; i < 4; i++) begin
      b.data = 32'h10 + 32'(i); b.resp = RESP_OKAY; b.last = (i == 3);
      exp_q.push_back(b);
      void'(mq.pop_front());
    end
    ar(8'd3, 3'd2, BURST_INCR);
    wait_done();
    @(negedge aclk);
    check("t1_arready", 64'(arready), 64'(1));
    tick();

    // Burst issued on an empty FIFO; each word appears the cycle after its push.
    ar(8'd3, 3'd2, BURST_INCR);
    @(negedge aclk);
    check("t2_empty_rvalid", 64'(rvalid), 64'(0));
    check("t2_arready_busy", 64'(arready), 64'(0));
    tick();
    for (int i = 0; i < 4; i++) begin
      push(32'h21 + 32'(i));
      exp_ok(1, i == 3);
      @(negedge aclk);
      check("t2_lat_rvalid", 64'(rvalid), 64'(1));
      check("t2_lat_rdata", 64'(rdata), 64'(32'h21 + 32'(i)));
      tick();
    end
    wait_done();
    @(negedge aclk);
    check("t2_arready", 64'(arready), 64'(1));
    tick();

    // Fill to full, hold a 17th word, then drain 16 with one burst.
    for (int i = 0; i < 16; i++) push(32'h300 + 32'(i));
    s_axis_tdata = 32'h3FF;
    s_axis_tvalid = 1'b1;
    repeat (2) begin
      @(negedge aclk);
      check("t3_full_tready", 64'(s_axis_tready), 64'(0));
      check("t3_full_count", 64'(fifo_count), 64'(16));
    end
    tick();
    exp_ok(16, 1'b1);
    fork
      push(32'h3FF);
      begin ar(8'd15, 3'd2, BURST_INCR); wait_done(); end
    join
    @(negedge aclk);
    check("t3_held_count", 64'(fifo_count), 64'(1));
    tick();

    // Table of bursts: legal ones consume model data, illegal ones leave the FIFO alone.
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < vec[k].pre; i++) push(32'h4000 + 32'(k*256 + 128 + i));
      if (vec[k].err) exp_err(int'(vec[k].len) + 1);
      else begin
        for (int i = 0; i <= int'(vec[k].len); i++) push(32'h4000 + 32'(k*256 + i));
        exp_ok(int'(vec[k].len) + 1, 1'b1);
      end
      ar(vec[k].len, vec[k].size, vec[k].burst);
      wait_done();
      @(negedge aclk);
      check("vec_arready", 64'(arready), 64'(1));
      check("vec_count", 64'(fifo_count), 64'(vec[k].exp_cnt));
      tick();
    end

    // rready toggling every cycle during a burst.
    for (int i = 0; i < 4; i++) push(32'h500 + 32'(i));
    exp_ok(4, 1'b1);
    done = 1'b0;
    fork
      begin ar(8'd3, 3'd2, BURST_INCR); wait_done(); done = 1'b1; end
      begin while (!done) begin tick(); rready = ~rready; end end
    join
    rready = 1'b1;
    @(negedge aclk);
    check("t5_count", 64'(fifo_count), 64'(mq.size()));
    tick();

    // Reset after the second beat abandons the burst and flushes the FIFO.
    for (int i = 0; i < 4; i++) push(32'h600 + 32'(i));
    exp_ok(2, 1'b0);
    ar(8'd3, 3'd2, BURST_INCR);
    wait_done();
    areset = 1'b1;
    tick();
    @(negedge aclk);
    check_rst_vals("midrst");
    mq.delete();
    tick();
    areset = 1'b0;
    @(negedge aclk);
    check("t6_arready", 64'(arready), 64'(1));
    tick();
    push(32'h777);
    exp_ok(1, 1'b1);
    ar(8'd0, 3'd2, BURST_INCR);
    wait_done();
    @(negedge aclk);
    check("t6_arready_end", 64'(arready), 64'(1));
    check("t6_count_end", 64'(fifo_count), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
